// File: rtl/vga_mode_pkg.sv
// rtl/vga_mode_pkg.sv - mode record, mode table and FSM encoding for vga_mode_ctrl
// VGA_MODE_POL_EN adds per-mode sync polarity bits to the record and table.
package vga_mode_pkg;

    typedef struct packed {
        logic [10:0] h_disp;
        logic [10:0] h_sync_start;
        logic [10:0] h_sync_end;
        logic [10:0] h_end;
        logic [10:0] v_disp;
        logic [10:0] v_sync_start;
        logic [10:0] v_sync_end;
        logic [10:0] v_end;
`ifdef VGA_MODE_POL_EN
        logic        h_pol;
        logic        v_pol;
`endif
    } mode_rec_t;

    localparam int MODE_REC_W = $bits(mode_rec_t);

`ifdef VGA_MODE_POL_EN
    localparam mode_rec_t MODE_TABLE [4] = '{
        '{11'd640,  11'd656,  11'd752,  11'd799,  11'd480,  11'd490,  11'd492,  11'd524,  1'b0, 1'b0},
        '{11'd800,  11'd840,  11'd968,  11'd1055, 11'd600,  11'd601,  11'd605,  11'd627,  1'b1, 1'b1},
        '{11'd1024, 11'd1048, 11'd1184, 11'd1343, 11'd768,  11'd771,  11'd777,  11'd805,  1'b0, 1'b0},
        '{11'd1280, 11'd1328, 11'd1440, 11'd1687, 11'd1024, 11'd1025, 11'd1028, 11'd1065, 1'b1, 1'b1}
    };
`else
    localparam mode_rec_t MODE_TABLE [4] = '{
        '{11'd640,  11'd656,  11'd752,  11'd799,  11'd480,  11'd490,  11'd492,  11'd524},
        '{11'd800,  11'd840,  11'd968,  11'd1055, 11'd600,  11'd601,  11'd605,  11'd627},
        '{11'd1024, 11'd1048, 11'd1184, 11'd1343, 11'd768,  11'd771,  11'd777,  11'd805},
        '{11'd1280, 11'd1328, 11'd1440, 11'd1687, 11'd1024, 11'd1025, 11'd1028, 11'd1065}
    };
`endif

    typedef enum logic [1:0] {
        ST_SWITCH   = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_EOF = 2'd3
    } state_t;

endpackage

// File: rtl/vga_mode_rom.sv
// rtl/vga_mode_rom.sv - combinational mode index to timing record lookup
// Kept separate so a board can substitute its own table.
module vga_mode_rom
    import vga_mode_pkg::*;
(
    input  logic [1:0]            idx,
    output logic [MODE_REC_W-1:0] rec
);

    assign rec = MODE_TABLE[idx];

endmodule

// File: rtl/vga_mode_ctrl.sv
// rtl/vga_mode_ctrl.sv - video mode controller: applies mode changes at end-of-frame
// VGA_MODE_POL_EN adds h_sync_pol/v_sync_pol outputs.
module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    output logic        req_err,
    input  logic [10:0] h_pos,
    input  logic [10:0] v_pos,
    output logic [10:0] h_disp,
    output logic [10:0] h_sync_start,
    output logic [10:0] h_sync_end,
    output logic [10:0] h_end,
    output logic [10:0] v_disp,
    output logic [10:0] v_sync_start,
    output logic [10:0] v_sync_end,
    output logic [10:0] v_end,
    output logic        sync_res,
    output logic        video_blank,
`ifdef VGA_MODE_POL_EN
    output logic        h_sync_pol,
    output logic        v_sync_pol,
`endif
    output logic [1:0]  cur_mode
);

    state_t                state_q, state_d;
    mode_rec_t             mode_q, mode_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            cur_q, cur_d;
    logic                  sync_res_q, sync_res_d;
    logic                  blank_q, blank_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [MODE_REC_W-1:0] rom_bits;
    mode_rec_t             rom_rec;
    logic                  eof;
    logic                  accept;
    logic [3:0]            cnt_inc;

    vga_mode_rom u_rom (
        .idx (pend_q),
        .rec (rom_bits)
    );

    assign rom_rec = mode_rec_t'(rom_bits);
    assign eof     = (h_pos == mode_q.h_end) && (v_pos == mode_q.v_end);
    assign accept  = req_valid && ready_q;
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        cur_d      = cur_q;
        sync_res_d = sync_res_q;
        blank_d    = blank_q;
        ready_d    = ready_q;
        err_d      = 1'b0;
        case (state_q)
            ST_SWITCH: begin
                state_d    = ST_SETTLE;
                cnt_d      = 4'd0;
                sync_res_d = 1'b0;
            end
            ST_SETTLE: begin
                if (eof) begin
                    if (cnt_inc == 4'(SETTLE_FRAMES)) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                        ready_d = 1'b1;
                        blank_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_RUN: begin
                // eof in the accept cycle is deliberately ignored: WAIT_EOF starts next cycle
                if (accept) begin
                    if (int'({30'd0, req_mode}) >= NUM_MODES) begin
                        err_d = 1'b1;
                    end else if (req_mode != cur_q) begin
                        pend_d  = req_mode;
                        state_d = ST_WAIT_EOF;
                        ready_d = 1'b0;
                        blank_d = 1'b1;
                    end
                end
            end
            ST_WAIT_EOF: begin
                if (eof) begin
                    mode_d     = rom_rec;
                    cur_d      = pend_q;
                    sync_res_d = 1'b1;
                    state_d    = ST_SWITCH;
                end
            end
            default: state_d = ST_SWITCH;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_SWITCH;
            mode_q     <= MODE_TABLE[0];
            cnt_q      <= 4'd0;
            pend_q     <= 2'd0;
            cur_q      <= 2'd0;
            sync_res_q <= 1'b1;
            blank_q    <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            sync_res_q <= sync_res_d;
            blank_q    <= blank_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign h_disp       = mode_q.h_disp;
    assign h_sync_start = mode_q.h_sync_start;
    assign h_sync_end   = mode_q.h_sync_end;
    assign h_end        = mode_q.h_end;
    assign v_disp       = mode_q.v_disp;
    assign v_sync_start = mode_q.v_sync_start;
    assign v_sync_end   = mode_q.v_sync_end;
    assign v_end        = mode_q.v_end;
    assign sync_res     = sync_res_q;
    assign video_blank  = blank_q;
    assign req_ready    = ready_q;
    assign req_err      = err_q;
    assign cur_mode     = cur_q;
`ifdef VGA_MODE_POL_EN
    assign h_sync_pol   = mode_q.h_pol;
    assign v_sync_pol   = mode_q.v_pol;
`endif

endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Video mode controller for the `vga_sync` timing generator. It holds the eight 11-bit timing words that drive the generator, accepts mode-change requests over a valid/ready handshake, and applies them only at end-of-frame. It resets the generator, blanks video until the new mode has run for a programmable number of frames, then reports ready. It sits between the CPU/OSD control logic and `vga_sync`.

## Interface
Parameters:
- `NUM_MODES`, 4: entries in the mode table; legal 1..4.
- `SETTLE_FRAMES`, 2: complete frames blanked after a switch; legal 1..15.

Ports:
- `clk` in 1: pixel clock, same clock as `vga_sync`.
- `res_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: mode-change request.
- `req_mode` in 2: requested mode index.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_err` out 1: one-cycle pulse when an accepted index is ≥ `NUM_MODES`.
- `h_pos`, `v_pos` in 11 each: beam position fed back from `vga_sync`.
- `h_disp`, `h_sync_start`, `h_sync_end`, `h_end` out 11 each: horizontal timing words to `vga_sync`.
- `v_disp`, `v_sync_start`, `v_sync_end`, `v_end` out 11 each: vertical timing words to `vga_sync`.
- `sync_res` out 1: active-high synchronous reset to `vga_sync`.
- `video_blank` out 1: forces RGB to black downstream.
- `cur_mode` out 2: index of the applied mode.

## Operation
- Mode table, indexed by mode; each entry is h disp/ss/se/end, v disp/ss/se/end:
  - 0: 640,656,752,799 / 480,490,492,524
  - 1: 800,840,968,1055 / 600,601,605,627
  - 2: 1024,1048,1184,1343 / 768,771,777,805
  - 3: 1280,1328,1440,1687 / 1024,1025,1028,1065
- `eof` = (`h_pos == h_end`) && (`v_pos == v_end`), evaluated combinationally against the currently driven timing words.
- States are SWITCH, SETTLE, RUN and WAIT_EOF. All outputs are registered.
- Reset values: state SWITCH, timing words = mode 0, `cur_mode` 0, `sync_res` 1, `video_blank` 1, `req_ready` 0, `req_err` 0, settle counter 0, pending mode 0.
- SWITCH: lasts exactly 1 cycle with `sync_res`=1, then goes to SETTLE with the counter cleared.
- SETTLE: counts `eof` cycles. When the count reaches `SETTLE_FRAMES`, the next state is RUN.
- RUN: `req_ready`=1 and `video_blank`=0. On a handshake:
  - index ≥ `NUM_MODES`: pulse `req_err` next cycle and stay in RUN.
  - index == `cur_mode`: no-op and stay in RUN.
  - otherwise: latch the pending mode and go to WAIT_EOF.
- WAIT_EOF: `req_ready`=0 and `video_blank`=1. On `eof`, load the pending table entry into the timing words, set `cur_mode` to it, and enter SWITCH.
- `video_blank` is 1 in every state except RUN.
- Requests outside RUN are not accepted; `req_valid` is simply held by the requester.
- If a request is accepted in the same cycle as `eof`, that `eof` is not used; the switch waits for the next frame end.
- Asserting `res_n` in any state immediately returns every output to its reset value and drops any pending request.

## Timing
- Accept in cycle T: `req_ready`=0 and `video_blank`=1 from T+1.
- `eof` in WAIT_EOF at cycle E: new timing words, new `cur_mode` and `sync_res`=1 all appear at E+1. `sync_res` returns to 0 at E+2.
- After reset deassertion: `sync_res` is 1 for the first edge, 0 from the second.
- Blank interval after a switch: the remainder of the old frame, plus 1 cycle, plus exactly `SETTLE_FRAMES` full new frames. `req_ready` rises the cycle after the final counted `eof`.
- Throughput: at most one mode change per (frame + settle) interval.

## Configuration
- `VGA_MODE_POL_EN` defined:
  - Adds outputs `h_sync_pol` and `v_sync_pol` (1 bit each; 1 = active-high).
  - Values per mode: 0 = 0/0, 1 = 1/1, 2 = 0/0, 3 = 1/1.
  - Updated together with the timing words. Reset value = mode 0 (0/0).
  - The top level XORs them into `h_sync`/`v_sync`.
- Undefined: the ports are absent, and sync is always active-high as produced by `vga_sync`.

## Structure
- Package `vga_mode_pkg` holds:
  - the mode-record typedef (8 × 11-bit words, plus polarity bits under the macro);
  - the 4-entry mode table constant;
  - the state encoding enum.
- One sub-module, `vga_mode_rom`: combinational index → record lookup, so the table can be replaced per board. The FSM, counter and registers live in `vga_mode_ctrl`.

## Test plan
- Reset release with `vga_sync` attached:
  - `h_end`=799, `v_end`=524, `sync_res` high for 1 cycle.
  - `video_blank` low and `req_ready` high after 2 full frames (2×800×525 + 2 cycles).
- Request mode 1 mid-frame at `h_pos`=100, `v_pos`=200:
  - Blank from next cycle; timing words change to 800/.../627 only the cycle after `h_pos`=799, `v_pos`=524.
  - `sync_res` pulse 1 cycle; `cur_mode`=1; RUN after 2×1056×628 further cycles.
- Request `req_mode`=1 while `cur_mode`=1: accepted, no blank, no `sync_res`, `req_ready` stays 1.
- With `NUM_MODES`=3, request mode 3: `req_err` pulses 1 cycle and state stays RUN.
- Request accepted exactly on the `eof` cycle: switch occurs one full frame later (800×525 cycles).
- `res_n` pulsed low during WAIT_EOF for pending mode 2:
  - Outputs return to mode 0 asynchronously and no switch to mode 2 occurs.
  - With `VGA_MODE_POL_EN`, the polarity bits read 0/0.
